// File: rtl/pkt_fetch_pkg.sv
// Shared widths, strides and FSM state type for the pkt_ram read-side fetch path.
package pkt_fetch_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int PKT_LEN_WIDTH   = 7;
    localparam int PKT_ADDR_STRIDE = 4;
    localparam int PKT_FIFO_DEPTH  = 4;

    localparam logic RST_ENABLED = 1'b1;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_ISSUE = 2'd1,
        PF_DRAIN = 2'd2,
        PF_DONE  = 2'd3
    } pf_state_e;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy count; sync active-high reset.
module pkt_fifo
    import pkt_fetch_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pkt_fetch.sv
// Read-side master for pkt_ram: walks a packet, absorbs the 1-cycle RAM latency, streams words out.
// Optional PKT_FETCH_STATS_EN adds stall_cnt_o (valid_o && !ready_i cycle counter).
module pkt_fetch
    import pkt_fetch_pkg::*;
#(
    parameter int AW          = ADDR_WIDTH,
    parameter int DW          = DATA_WIDTH,
    parameter int LW          = PKT_LEN_WIDTH,
    parameter int ADDR_STRIDE = PKT_ADDR_STRIDE,
    parameter int FIFO_DEPTH  = PKT_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [LW-1:0] len_i,
    output logic [AW-1:0] addr_o,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          done_o
`ifdef PKT_FETCH_STATS_EN
    ,
    output logic [15:0]   stall_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pf_state_e     state;
    logic [AW-1:0] next_addr;
    logic [LW-1:0] remaining;
    logic          addr_vld;
    logic          addr_last;
    logic          rd_pend;
    logic          rd_last;

    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW:0]   fifo_rdata;
    logic          pop;
    logic [CW:0]   in_flight;
    logic          can_issue;
    logic          last_hs;

    // addr_vld: address on addr_o this cycle; rd_pend: its data is on data_i this cycle.
    assign in_flight = {1'b0, fifo_cnt} + (CW + 1)'(addr_vld) + (CW + 1)'(rd_pend);
    assign can_issue = !fifo_full && (in_flight < (CW + 1)'(FIFO_DEPTH));

    assign valid_o = !fifo_empty;
    assign data_o  = fifo_rdata[DW-1:0];
    assign last_o  = fifo_rdata[DW];
    assign pop     = valid_o && ready_i;
    assign last_hs = pop && last_o && (fifo_cnt == CW'(1)) && !rd_pend && !addr_vld;

    pkt_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .wdata ({rd_last, data_i}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            state     <= PF_IDLE;
            addr_o    <= '0;
            next_addr <= '0;
            remaining <= '0;
            addr_vld  <= 1'b0;
            addr_last <= 1'b0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            addr_vld  <= 1'b0;
            addr_last <= 1'b0;
            rd_pend   <= addr_vld;
            rd_last   <= addr_last;
            done_o    <= 1'b0;
            case (state)
                PF_IDLE: begin
                    // First address goes out on the accept edge so addr_o=base in the next cycle.
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            addr_o    <= base_addr_i;
                            addr_vld  <= 1'b1;
                            addr_last <= (len_i == LW'(1));
                            next_addr <= base_addr_i + AW'(ADDR_STRIDE);
                            remaining <= len_i - LW'(1);
                            state     <= (len_i == LW'(1)) ? PF_DRAIN : PF_ISSUE;
                        end else begin
                            done_o <= 1'b1;
                            state  <= PF_DONE;
                        end
                    end
                end
                PF_ISSUE: begin
                    if (can_issue) begin
                        addr_o    <= next_addr;
                        addr_vld  <= 1'b1;
                        addr_last <= (remaining == LW'(1));
                        next_addr <= next_addr + AW'(ADDR_STRIDE);
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state <= PF_DRAIN;
                        end
                    end
                end
                PF_DRAIN: begin
                    // Leaving on the last handshake itself makes done_o land the following cycle.
                    if (last_hs) begin
                        done_o <= 1'b1;
                        state  <= PF_DONE;
                    end
                end
                PF_DONE: begin
                    busy_o <= 1'b0;
                    state  <= PF_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= PF_IDLE;
                end
            endcase
        end
    end

`ifdef PKT_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            stall_cnt_o <= '0;
        end else if (state == PF_IDLE && start_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_fetch.sv
// Self-checking bench for pkt_fetch: RAM model plus queue-based beat scoreboard.
module tb_pkt_fetch;
    import pkt_fetch_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int LW = PKT_LEN_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;
`ifdef PKT_FETCH_STATS_EN
    logic [15:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    pkt_fetch #(
        .AW          (AW),
        .DW          (DW),
        .LW          (LW),
        .ADDR_STRIDE (PKT_ADDR_STRIDE),
        .FIFO_DEPTH  (PKT_FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .addr_o      (addr_o),
        .data_i      (data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef PKT_FETCH_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // pkt_ram: 64 words, registered read every cycle.
    logic [DW-1:0] ram [64];
    always @(posedge clk) data_i <= ram[addr_o[7:2]];

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q [$];
    int            popped = 0;
    int            stall_model = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet content as software sees it: consecutive words from the base word index.
    task automatic load_pkt(input logic [AW-1:0] base, input logic [LW-1:0] len);
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(ram[(int'(base[7:2]) + i) % 64]);
        end
    endtask

    // Observe the current cycle, update the model, then advance to just after the next edge.
    task automatic cyc();
        logic [DW-1:0] e;
        if (rst) begin
            exp_q.delete();
            prev_stall  = 1'b0;
            stall_model = 0;
        end else begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(data_o), 64'(e));
                    chk("beat_last", 64'(last_o), 64'(exp_q.size() == 0));
                    popped++;
                end
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(valid_o), 64'd1);
                chk("stall_data", 64'(data_o), 64'(prev_data));
                chk("stall_last", 64'(last_o), 64'(prev_last));
            end
            if (start_i && !busy_o) begin
                stall_model = 0;
                load_pkt(base_addr_i, len_i);
            end
            if (valid_o && !ready_i && stall_model < 65535) stall_model++;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int budget, input bit rnd);
        int n = 0;
        while (!done_o && n < budget) begin
            if (rnd) begin
                ready_i     = ($urandom_range(0, 3) != 0);
                start_i     = ($urandom_range(0, 7) == 0);
                base_addr_i = AW'($urandom_range(0, 63) * 4);
                len_i       = LW'($urandom_range(1, 20));
            end
            cyc();
            n++;
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        cyc();
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_done", 64'(done_o), 64'd0);
    endtask

    task automatic start_pkt(input logic [AW-1:0] base, input logic [LW-1:0] len);
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        cyc();
        start_i     = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int            p0;
        int            n;
        int            issued;

        for (int i = 0; i < 64; i++) ram[i] = DW'($urandom);
        rst = 1'b1; start_i = 1'b0; ready_i = 1'b1; base_addr_i = '0; len_i = '0;
        repeat (3) cyc();
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        rst = 1'b0;
        cyc();

        // Directed timing: base 0x40, three words, ready held high.
        start_pkt(AW'('h40), LW'(3));
        chk("a_addr_t1", 64'(addr_o), 64'h40);
        chk("a_busy_t1", 64'(busy_o), 64'd1);
        chk("a_valid_t1", 64'(valid_o), 64'd0);
        cyc();
        chk("a_addr_t2", 64'(addr_o), 64'h44);
        chk("a_valid_t2", 64'(valid_o), 64'd0);
        cyc();
        chk("a_addr_t3", 64'(addr_o), 64'h48);
        chk("a_valid_t3", 64'(valid_o), 64'd1);
        chk("a_data_t3", 64'(data_o), 64'(ram[16]));
        chk("a_last_t3", 64'(last_o), 64'd0);
        cyc();
        chk("a_data_t4", 64'(data_o), 64'(ram[17]));
        cyc();
        chk("a_data_t5", 64'(data_o), 64'(ram[18]));
        chk("a_last_t5", 64'(last_o), 64'd1);
        chk("a_done_t5", 64'(done_o), 64'd0);
        cyc();
        chk("a_done_t6", 64'(done_o), 64'd1);
        chk("a_valid_t6", 64'(valid_o), 64'd0);
        cyc();
        chk("a_busy_t7", 64'(busy_o), 64'd0);
        chk("a_done_t7", 64'(done_o), 64'd0);
        chk("a_queue", 64'(exp_q.size()), 64'd0);

        // Zero-length packet: immediate done, no beats, address untouched.
        a = addr_o;
        start_pkt(AW'('h80), LW'(0));
        chk("z_done", 64'(done_o), 64'd1);
        chk("z_valid", 64'(valid_o), 64'd0);
        chk("z_addr", 64'(addr_o), 64'(a));
        cyc();
        chk("z_busy", 64'(busy_o), 64'd0);
        chk("z_valid2", 64'(valid_o), 64'd0);
        chk("z_addr2", 64'(addr_o), 64'(a));

        // Backpressure: 8 words from 0, ready low for 5 cycles after the 2nd beat.
        p0 = popped;
        start_pkt('0, LW'(8));
        n = 0;
        while (popped - p0 < 2 && n < 50) begin cyc(); n++; end
        chk("s_two_beats", 64'(popped - p0), 64'd2);
        ready_i = 1'b0;
        repeat (5) begin
            cyc();
            issued = int'(addr_o >> 2) + 1;
            chk("s_credit", 64'((issued - (popped - p0)) <= PKT_FIFO_DEPTH), 64'd1);
        end
        ready_i = 1'b1;
        run_to_done(200, 1'b0);

        // Second start while busy must be ignored.
        start_pkt(AW'($urandom_range(0, 50) * 4), LW'(4));
        cyc();
        start_pkt(AW'('h100), LW'(5));
        run_to_done(200, 1'b0);
        repeat (3) begin
            cyc();
            chk("ign_no_beat", 64'(valid_o), 64'd0);
        end

        // Reset while the 2nd beat of a 6-word packet is presented.
        p0 = popped;
        start_pkt(AW'($urandom_range(0, 50) * 4), LW'(6));
        n = 0;
        while (!(valid_o && popped - p0 == 1) && n < 50) begin cyc(); n++; end
        chk("r_second_beat", 64'(valid_o && popped - p0 == 1), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("r_valid", 64'(valid_o), 64'd0);
        chk("r_busy", 64'(busy_o), 64'd0);
        chk("r_done", 64'(done_o), 64'd0);
        start_pkt(AW'($urandom_range(0, 50) * 4), LW'(5));
        run_to_done(200, 1'b0);

`ifdef PKT_FETCH_STATS_EN
        // Stall counter: 4 stalled cycles on a 3-word packet, cleared by the next start.
        start_pkt(AW'($urandom_range(0, 50) * 4), LW'(3));
        n = 0;
        while (!valid_o && n < 20) begin cyc(); n++; end
        ready_i = 1'b0;
        repeat (4) cyc();
        ready_i = 1'b1;
        run_to_done(200, 1'b0);
        chk("st_count", 64'(stall_cnt_o), 64'd4);
        chk("st_model", 64'(stall_cnt_o), 64'(stall_model));
        start_pkt(AW'($urandom_range(0, 50) * 4), LW'(2));
        chk("st_clear", 64'(stall_cnt_o), 64'd0);
        run_to_done(200, 1'b0);
`endif

        // Randomised packets with random backpressure and stray start requests.
        for (int k = 0; k < 10; k++) begin
            start_pkt(AW'($urandom_range(0, 63) * 4), LW'($urandom_range(1, 20)));
            run_to_done(600, 1'b1);
`ifdef PKT_FETCH_STATS_EN
            chk("rnd_stall", 64'(stall_cnt_o), 64'(stall_model));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_fetch.md
Name: pkt_fetch

Overview:
Read-side master for pkt_ram. On a start command it walks a packet stored in pkt_ram word by word and drives the RAM address. It absorbs the RAM's one-cycle registered read latency and streams the returned words downstream on a valid/ready interface with full backpressure. It sits between pkt_ram and the parser/match pipeline.

Parameters:
AW, `ADDR_WIDTH, width of the RAM byte address (pkt_ram indexes words by addr[AW-1:2]).
DW, `DATA_WIDTH, width of one RAM word / stream beat.
LW, 7, packet length field width in words (max 64 words).
ADDR_STRIDE, 4, addr_o increment per word.
FIFO_DEPTH, 4, output buffer entries; must be ≥3.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high (rst == `RST_ENABLED).
start_i  in  1  start request; sampled only when busy_o=0.
base_addr_i  in  AW  byte address of the first word; sampled with start_i.
len_i  in  LW  packet length in words; sampled with start_i.
addr_o  out  AW  address to pkt_ram.addr_i.
data_i  in  DW  from pkt_ram.data_o; valid the cycle after addr_o is presented.
data_o  out  DW  stream beat.
valid_o  out  1  beat valid.
last_o  out  1  final beat of the packet; qualified by valid_o.
ready_i  in  1  downstream accept.
busy_o  out  1  fetch in progress.
done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, FIFO emptied, counters cleared. Reset mid-packet aborts silently; no done_o pulse. Any in-flight RAM read is discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start_i=1 latches base, len and next_addr=base.
    - len≠0 → ISSUE.
    - len=0 → DONE.
  - ISSUE: each cycle with issue permitted, register addr_o=next_addr, set rd_pend, then next_addr += ADDR_STRIDE and remaining -= 1. When the last address issues → DRAIN.
  - DRAIN: wait until no read is pending, the FIFO is empty, and the last beat has handshaken → DONE.
  - DONE: done_o=1 for exactly this cycle → IDLE.
- busy_o=1 in ISSUE, DRAIN and DONE. start_i while busy_o=1 is ignored; it is not queued.
- Address issue rule: issue only when fifo_cnt + outstanding reads < FIFO_DEPTH, so the FIFO can never overflow.
  - Outstanding reads = registered address issued last cycle plus data arriving this cycle; at most 2.
- addr_o holds its last value when not issuing. The RAM reads every cycle, so only rd_pend qualifies data_i.
- Capture: data_i is pushed into the FIFO in the cycle after the corresponding addr_o cycle. The last-word tag is pushed alongside.
- Timing from start accepted in cycle T:
  - addr_o=base in T+1.
  - data_i valid in T+2.
  - valid_o first high in T+3.
- Throughput: sustained 1 beat/cycle while ready_i=1.
- Stream rules:
  - While valid_o=1 and ready_i=0, data_o and last_o hold stable.
  - valid_o never drops without a handshake.
  - Simultaneous FIFO push and pop is allowed when full-minus-one.
- Arithmetic: addresses wrap modulo 2^AW. Packets crossing the 64-word RAM end are software error; no check is performed.
- done_o asserts the cycle after the handshake of the last_o beat.

Optional Feature:
PKT_FETCH_STATS_EN:
- Defined: adds output stall_cnt_o [15:0]. It counts cycles with valid_o=1 and ready_i=0, saturates at 16'hFFFF, clears on start accept and on reset, and holds after DONE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- def.v (shared) already provides `RST_ENABLED, `ZERO_WORD, `ADDR_WIDTH, `DATA_WIDTH.
- Add to def.v: `PKT_LEN_WIDTH, the FSM state encodings `PF_IDLE, `PF_ISSUE, `PF_DRAIN, `PF_DONE, and `PKT_ADDR_STRIDE.
- One sub-module: pkt_fifo, a synchronous DW+1-bit FIFO with push, pop, full, empty and count, sync active-high reset.

Test Plan:
- RAM words 16..18 = A, B, C; start base=0x40 len=3 at T; ready_i=1 → addr_o 0x40, 0x44, 0x48 in T+1..T+3; beats A, B, C in T+3..T+5, last_o with C; done_o at T+6; busy_o=0 at T+7.
- base=0 len=8; ready_i low for 5 cycles after the 2nd beat → data_o/last_o stable while stalled, no issue beyond FIFO_DEPTH credit, all 8 words in order, no duplicates.
- start len=0 at T → done_o=1 at T+1, valid_o never asserts, addr_o unchanged.
- start len=4 then start_i=1 again at T+2 with base=0x100 → second start ignored; only the 4 beats of the first packet appear.
- rst asserted at the 2nd beat of a len=6 fetch → next cycle valid_o=0, busy_o=0, done_o=0; a new start fetches correctly from T+3.
- With PKT_FETCH_STATS_EN: len=3, ready_i low for 4 cycles while valid_o=1 → stall_cnt_o=4 after done_o; the next start clears it to 0.
